mux2_rr_arbiter: RTL and testbench

//  Round-robin arbiter and data path for two valid/ready sources sharing one output channel.

---
 rtl/mux_arb_pkg.sv | 31 +++
 rtl/mux2_bus.sv | 23 ++
 rtl/mux2_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module  : mux_arb_pkg
// Brief   : Shared state encoding and select constants for the 2-source
//           round-robin mux arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_GNT_A = ST_GNT_A,
        S_GNT_B = ST_GNT_B
    } arb_state_e;

    // Grant state that corresponds to a given select value.
    function automatic arb_state_e grant_state(input logic sel_v);
        return (sel_v == SEL_B) ? S_GNT_B : S_GNT_A;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_bus.sv
// ============================================================================
// Module  : mux2_bus
// Brief   : WIDTH-wide 2:1 mux, y = ~sel&a | sel&b per bit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mux2_bus #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y_o[i] = (~sel_i & a_i[i]) | (sel_i & b_i[i]);
    end

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module  : mux2_rr_arbiter
// Brief   : Round-robin burst arbiter and 2:1 data path for two valid/ready
//           sources sharing one output channel.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic w_gnt_a;
    logic w_gnt_b;
    logic w_cur_sel;
    logic w_x_valid;
    logic w_other_valid;
    logic w_xfer;
    logic w_forced_end;

    assign w_gnt_a       = (state_q == S_GNT_A);
    assign w_gnt_b       = (state_q == S_GNT_B);
    assign w_cur_sel     = w_gnt_b ? SEL_B : SEL_A;
    assign w_x_valid     = w_gnt_b ? b_valid : a_valid;
    assign w_other_valid = w_gnt_b ? a_valid : b_valid;

    // sel depends on state only, so no input reaches it combinationally.
    assign sel       = w_gnt_b;
    assign out_valid = (w_gnt_a & a_valid) | (w_gnt_b & b_valid);
    assign a_ready   = w_gnt_a & a_valid & out_ready;
    assign b_ready   = w_gnt_b & b_valid & out_ready;
    assign w_xfer    = out_valid & out_ready;
    assign w_forced_end = w_xfer & (cnt_q == CNT_LAST);

    mux2_bus #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a_i   (a_data),
        .b_i   (b_data),
        .sel_i (sel),
        .y_o   (out_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (a_valid && b_valid) begin
                    state_d = grant_state(~last_q);
                end else if (a_valid) begin
                    state_d = S_GNT_A;
                end else if (b_valid) begin
                    state_d = S_GNT_B;
                end
            end

            S_GNT_A, S_GNT_B: begin
                if (!w_x_valid || w_forced_end) begin
                    cnt_d  = '0;
                    last_d = w_cur_sel;
                    if (w_other_valid) begin
                        state_d = grant_state(~w_cur_sel);
                    end else if (w_forced_end) begin
                        // forced end implies the current source is still valid
                        state_d = state_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (w_xfer) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= SEL_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// Module  : tb_mux2_rr_arbiter
// Brief   : Self-checking bench: vector table, hand sequences and a random
//           phase against a behavioural round-robin model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;

    logic       a_ready, b_ready, out_valid, sel;
    logic [7:0] out_data;
    logic       a_ready1, b_ready1, out_valid1, sel1;
    logic [7:0] out_data1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(8), .BURST_LEN(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel)
    );

    mux2_rr_arbiter #(.WIDTH(8), .BURST_LEN(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
        .sel(sel1)
    );

    typedef struct packed {
        logic       av, bv, rdy;
        logic [7:0] ad, bd;
        logic       eov, esel, ear, ebr;
        logic [7:0] eod;
    } vec_t;

    vec_t tbl [37];

    function automatic vec_t mk(input logic av, bv, rdy, input logic [7:0] ad, bd,
                                input logic eov, esel, ear, ebr, input logic [7:0] eod);
        vec_t v;
        v.av = av; v.bv = bv; v.rdy = rdy; v.ad = ad; v.bd = bd;
        v.eov = eov; v.esel = esel; v.ear = ear; v.ebr = ebr; v.eod = eod;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, bv, rdy, input logic [7:0] ad, bd);
        a_valid = av; b_valid = bv; out_ready = rdy; a_data = ad; b_data = bd;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string nm, input logic eov, esel, ear, ebr,
                            input logic [7:0] eod);
        check({nm, "_ov"},   {31'd0, out_valid}, {31'd0, eov});
        check({nm, "_sel"},  {31'd0, sel},       {31'd0, esel});
        check({nm, "_ar"},   {31'd0, a_ready},   {31'd0, ear});
        check({nm, "_br"},   {31'd0, b_ready},   {31'd0, ebr});
        check({nm, "_data"}, {24'd0, out_data},  {24'd0, eod});
    endtask

    // Behavioural model: owner 0=none,1=A,2=B; beats taken in the current grant.
    int own [2];
    int beats [2];
    int lst [2];
    int bl [2] = '{4, 1};

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; beats[k] = 0; lst[k] = 1;
        end
    endtask

    task automatic m_check(input int k, input string nm);
        logic       ov, s, ar, br;
        logic [7:0] od;
        s  = (own[k] == 2);
        ov = (own[k] == 1) ? a_valid : (own[k] == 2) ? b_valid : 1'b0;
        ar = (own[k] == 1) && a_valid && out_ready;
        br = (own[k] == 2) && b_valid && out_ready;
        od = s ? b_data : a_data;
        if (k == 0) begin
            chk_main(nm, ov, s, ar, br, od);
        end else begin
            check({nm, "_ov1"},   {31'd0, out_valid1}, {31'd0, ov});
            check({nm, "_sel1"},  {31'd0, sel1},       {31'd0, s});
            check({nm, "_ar1"},   {31'd0, a_ready1},   {31'd0, ar});
            check({nm, "_br1"},   {31'd0, b_ready1},   {31'd0, br});
            check({nm, "_data1"}, {24'd0, out_data1},  {24'd0, od});
        end
    endtask

    task automatic m_step(input int k);
        logic xv, yv, took;
        int   other;
        if (own[k] == 0) begin
            if (a_valid && b_valid) own[k] = (lst[k] == 0) ? 2 : 1;
            else if (a_valid)       own[k] = 1;
            else if (b_valid)       own[k] = 2;
        end else begin
            other = 3 - own[k];
            xv    = (own[k] == 1) ? a_valid : b_valid;
            yv    = (own[k] == 1) ? b_valid : a_valid;
            took  = xv && out_ready;
            if (!xv || (took && beats[k] + 1 == bl[k])) begin
                lst[k]   = own[k] - 1;
                beats[k] = 0;
                own[k]   = yv ? other : (xv ? own[k] : 0);
            end else if (took) begin
                beats[k]++;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        // Tests 1-4 as one continuous vector table on the BURST_LEN=4 instance.
        tbl[0] = mk(1, 0, 1, 8'h11, 8'h00, 0, 0, 0, 0, 8'h11);
        tbl[1] = mk(1, 0, 1, 8'h11, 8'h00, 1, 0, 1, 0, 8'h11);
        tbl[2] = mk(1, 0, 1, 8'h12, 8'h00, 1, 0, 1, 0, 8'h12);
        tbl[3] = mk(1, 0, 1, 8'h13, 8'h00, 1, 0, 1, 0, 8'h13);
        tbl[4] = mk(1, 0, 1, 8'h14, 8'h00, 1, 0, 1, 0, 8'h14);
        tbl[5] = mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00);
        tbl[6] = mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00);
        tbl[7] = mk(1, 1, 1, 8'h21, 8'h31, 0, 0, 0, 0, 8'h21);
        for (int i = 8;  i < 12; i++) tbl[i] = mk(1, 1, 1, 8'h21, 8'h31, 1, 1, 0, 1, 8'h31);
        for (int i = 12; i < 16; i++) tbl[i] = mk(1, 1, 1, 8'h21, 8'h31, 1, 0, 1, 0, 8'h21);
        for (int i = 16; i < 20; i++) tbl[i] = mk(1, 1, 1, 8'h21, 8'h31, 1, 1, 0, 1, 8'h31);
        for (int i = 20; i < 25; i++) tbl[i] = mk(1, 1, 0, 8'h21, 8'h31, 1, 0, 0, 0, 8'h21);
        for (int i = 25; i < 29; i++) tbl[i] = mk(1, 1, 1, 8'h21, 8'h31, 1, 0, 1, 0, 8'h21);
        tbl[29] = mk(1, 1, 1, 8'h21, 8'h31, 1, 1, 0, 1, 8'h31);
        tbl[30] = mk(1, 1, 1, 8'h21, 8'h31, 1, 1, 0, 1, 8'h31);
        tbl[31] = mk(1, 0, 1, 8'h21, 8'h31, 0, 1, 0, 0, 8'h31);
        for (int i = 32; i < 36; i++) tbl[i] = mk(1, 1, 1, 8'h21, 8'h31, 1, 0, 1, 0, 8'h21);
        tbl[36] = mk(1, 1, 1, 8'h21, 8'h31, 1, 1, 0, 1, 8'h31);

        rst_n = 1'b0;
        drive(0, 0, 1, 8'h5A, 8'hA5);
        #2;
        chk_main("reset_t0", 0, 0, 0, 0, 8'h5A);
        adv();
        adv();
        drive(1, 1, 1, 8'h5A, 8'hA5);
        #1;
        chk_main("reset_held", 0, 0, 0, 0, 8'h5A);
        rst_n = 1'b1;

        for (int i = 0; i < 37; i++) begin
            drive(tbl[i].av, tbl[i].bv, tbl[i].rdy, tbl[i].ad, tbl[i].bd);
            @(negedge clk);
            chk_main($sformatf("vec%0d", i), tbl[i].eov, tbl[i].esel,
                     tbl[i].ear, tbl[i].ebr, tbl[i].eod);
            adv();
        end

        // Test 5: leave with last=A, grant A, reach cnt=2, reset mid-burst.
        drive(0, 0, 1, 8'h00, 8'h00); adv();
        drive(1, 0, 1, 8'h41, 8'h00); adv();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 8'h41, 8'h00);
            @(negedge clk);
            chk_main($sformatf("midburst%0d", i), 1, 0, 1, 0, 8'h41);
            adv();
        end
        drive(1, 1, 1, 8'h42, 8'h52);
        #1;
        chk_main("prerst", 1, 0, 1, 0, 8'h42);
        rst_n = 1'b0;
        #1;
        chk_main("async_rst", 0, 0, 0, 0, 8'h42);
        adv();
        rst_n = 1'b1;
        @(negedge clk);
        chk_main("post_rst_idle", 0, 0, 0, 0, 8'h42);
        adv();
        @(negedge clk);
        chk_main("post_rst_grant", 1, 0, 1, 0, 8'h42);
        adv();

        // Test 6: BURST_LEN=1 instance alternates every beat.
        drive(1, 1, 1, 8'h61, 8'h71);
        pulse_reset();
        @(negedge clk);
        check("bl1_idle_ov", {31'd0, out_valid1}, 32'd0);
        adv();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bl1_sel%0d", i), {31'd0, sel1}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("bl1_ov%0d", i), {31'd0, out_valid1}, 32'd1);
            check($sformatf("bl1_data%0d", i), {24'd0, out_data1},
                  (i % 2 == 0) ? 32'h61 : 32'h71);
            adv();
        end

        // Random phase against the behavioural model, both instances.
        drive(0, 0, 0, 8'h00, 8'h00);
        pulse_reset();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                m_reset();
                @(negedge clk);
                m_check(0, $sformatf("rnd_rst%0d", c));
                m_check(1, $sformatf("rnd_rst%0d", c));
                adv();
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
                m_check(0, $sformatf("rnd%0d", c));
                m_check(1, $sformatf("rnd%0d", c));
                m_step(0);
                m_step(1);
                adv();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
